// File: rtl/mandelbrot_pixel_sink.sv
// Pixel sink for the Mandelbrot engine: tracks raster position, packs two 4-bit
// iteration counts per byte and queues them in a first-word-fall-through FIFO.
module mandelbrot_pixel_sink #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       running,
    input  logic       new_ctr,
    input  logic [3:0] ctr_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sof,
    output logic       out_eol,
    output logic       frame_done,
    output logic       overflow,
    input  logic       clear_err
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] data;
    } entry_t;

    logic          run_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          half;
    logic [3:0]    lo;

    logic          restart;
    logic          accept;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic          line_end;
    logic          frame_end;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    entry_t        wr_entry;
    entry_t        head;
    entry_t        mem [FIFO_DEPTH];

    // A rising edge of running restarts the raster and swallows a coincident strobe.
    assign restart   = running & ~run_q;
    assign accept    = new_ctr & ~restart;
    assign push      = accept & half;
    assign line_end  = (x == X_LAST);
    assign frame_end = line_end & (y == Y_LAST);

    assign wr_entry = '{sof:  (x == XW'(1)) && (y == '0),
                        eol:  line_end,
                        data: {ctr_in, lo}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= running;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            y    <= '0;
            half <= 1'b0;
            lo   <= '0;
        end else if (restart) begin
            x    <= '0;
            y    <= '0;
            half <= 1'b0;
        end else if (accept) begin
            half <= ~half;
            if (!half) begin
                lo <= ctr_in;
            end
            if (line_end) begin
                x <= '0;
                y <= frame_end ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept & frame_end;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & out_ready;
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // At full with a pop, the write lands in the slot being vacated this edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push & full & ~pop) begin
            overflow <= 1'b1;
        end else if (clear_err) begin
            overflow <= 1'b0;
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = ~empty;
    assign out_data  = empty ? 8'h00 : head.data;
    assign out_sof   = ~empty & head.sof;
    assign out_eol   = ~empty & head.eol;

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// Directed plus random bench for mandelbrot_pixel_sink against a pixel-index
// and byte-queue reference model.
module tb_mandelbrot_pixel_sink;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       running;
    logic       new_ctr;
    logic [3:0] ctr_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sof;
    logic       out_eol;
    logic       frame_done;
    logic       overflow;
    logic       clear_err;

    always #5 clk = ~clk;

    mandelbrot_pixel_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .running(running), .new_ctr(new_ctr),
        .ctr_in(ctr_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .out_eol(out_eol),
        .frame_done(frame_done), .overflow(overflow), .clear_err(clear_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: queue of {sof, eol, byte}, pixel index within the frame.
    logic [9:0] q[$];
    int         pix = 0;
    logic [3:0] held = 4'h0;
    bit         prev_run = 0;
    bit         m_ovf = 0;
    bit         m_fd = 0;
    bit         run_r = 0;

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [9:0] h;
        h = (q.size() > 0) ? q[0] : 10'h000;
        check("out_valid",  10'(out_valid),  10'(q.size() > 0));
        check("out_data",   10'(out_data),   10'(h[7:0]));
        check("out_sof",    10'(out_sof),    10'(h[9]));
        check("out_eol",    10'(out_eol),    10'(h[8]));
        check("frame_done", 10'(frame_done), 10'(m_fd));
        check("overflow",   10'(overflow),   10'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        pix      = 0;
        prev_run = 0;
        m_ovf    = 0;
        m_fd     = 0;
    endtask

    task automatic step(input bit run, input bit nc, input logic [3:0] c,
                        input bit rdy, input bit clr);
        bit         rs;
        bit         set_ovf;
        logic [9:0] e;
        running   = run;
        new_ctr   = nc;
        ctr_in    = c;
        out_ready = rdy;
        clear_err = clr;
        @(posedge clk);
        rs       = run && !prev_run;
        prev_run = run;
        set_ovf  = 0;
        m_fd     = 0;
        if ((q.size() > 0) && rdy) void'(q.pop_front());
        if (rs) begin
            pix = 0;
        end else if (nc) begin
            if (pix % 2 == 0) begin
                held = c;
            end else begin
                e = {1'(pix == 1), 1'((pix % W) == W - 1), c, held};
                if (q.size() < D) q.push_back(e);
                else set_ovf = 1;
            end
            pix++;
            if (pix == W * H) begin
                pix  = 0;
                m_fd = 1;
            end
        end
        if (clr) m_ovf = 0;
        if (set_ovf) m_ovf = 1;
        #1;
        check_outputs();
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; running = 0; new_ctr = 0; ctr_in = 0; out_ready = 0; clear_err = 0;
        #12;
        model_reset();
        check_outputs();
        reset = 1'b0;

        // Full frame with 1..8; last strobe coincides with running falling.
        step(1, 0, 4'h0, 1, 0);
        step(1, 1, 4'h1, 1, 0);
        check("one_pix_valid", 10'(out_valid), 10'h0);
        step(1, 1, 4'h2, 1, 0);
        check("ff_byte0", {out_sof, out_eol, out_data}, {2'b10, 8'h21});
        step(1, 1, 4'h3, 1, 0);
        step(1, 1, 4'h4, 1, 0);
        check("ff_byte1", {out_sof, out_eol, out_data}, {2'b01, 8'h43});
        step(1, 1, 4'h5, 1, 0);
        step(1, 1, 4'h6, 1, 0);
        check("ff_byte2", {out_sof, out_eol, out_data}, {2'b00, 8'h65});
        step(1, 1, 4'h7, 1, 0);
        step(0, 1, 4'h8, 1, 0);
        check("ff_byte3", {out_sof, out_eol, out_data}, {2'b01, 8'h87});
        check("ff_done", 10'(frame_done), 10'h1);
        step(0, 0, 4'h0, 1, 0);
        check("ff_done_once", 10'(frame_done), 10'h0);

        // Overrun: ten pixels with no consumer, fifth byte dropped.
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 4'($urandom), 0, 0);
        check("ovr_set", 10'(overflow), 10'h1);
        for (int i = 0; i < 6; i++) step(1, 0, 4'h0, 1, 0);
        check("ovr_drained", 10'(out_valid), 10'h0);
        step(1, 0, 4'h0, 1, 1);
        check("ovr_clear", 10'(overflow), 10'h0);

        // Push at full with a simultaneous pop.
        step(0, 0, 4'h0, 0, 0);
        step(1, 0, 4'h0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 4'($urandom), 0, 0);
        step(1, 1, 4'($urandom), 1, 0);
        check("full_pop_no_ovf", 10'(overflow), 10'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 4'h0, 1, 0);

        // Clear and overrun in the same cycle: set wins.
        for (int i = 0; i < 8; i++) step(1, 1, 4'($urandom), 0, 0);
        step(1, 1, 4'($urandom), 0, 0);
        step(1, 1, 4'($urandom), 0, 1);
        check("set_wins", 10'(overflow), 10'h1);
        for (int i = 0; i < 6; i++) step(1, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 1);

        // Mid-line restart discards the held nibble.
        step(0, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 4'($urandom), 1, 0);
        step(0, 0, 4'h0, 1, 0);
        step(1, 0, 4'h0, 1, 0);
        step(1, 1, 4'hA, 0, 0);
        step(1, 1, 4'hB, 0, 0);
        check("restart_byte", {out_sof, out_eol, out_data}, {2'b10, 8'hBA});
        step(1, 0, 4'h0, 1, 0);

        // Mid-frame asynchronous reset.
        step(1, 1, 4'h5, 0, 0);
        async_reset();

        // Random traffic.
        run_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) run_r = ~run_r;
            step(run_r, 1'($urandom_range(0, 1)), 4'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mandelbrot_pixel_sink.md
# mandelbrot_pixel_sink

Consumes the iteration-count stream produced by the Mandelbrot engine: one 4-bit `ctr_in` value per `new_ctr` pulse, in raster order. It tracks the pixel position and packs two pixels per byte. Packed bytes are buffered in a small FIFO and presented on a valid/ready byte stream with start-of-frame and end-of-line markers. It sits between the engine and the output serializer/pin driver and absorbs short stalls. A FIFO overrun is flagged sticky rather than stalling the engine, because the engine has no backpressure.

## Interface

Parameters:
- `WIDTH`, 640: pixels per line. Must be even.
- `HEIGHT`, 480: lines per frame.
- `FIFO_DEPTH`, 4: byte entries. Power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `running`  in  1  engine busy flag; a 0→1 transition marks a new frame.
- `new_ctr`  in  1  one-cycle pixel strobe from the engine.
- `ctr_in`  in  4  iteration count of the current pixel.
- `out_data`  out  8  packed byte: even-x pixel in [3:0], odd-x pixel in [7:4].
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the byte when `out_valid & out_ready`.
- `out_sof`  out  1  head byte is the first byte of a frame (x=0,1; y=0).
- `out_eol`  out  1  head byte is the last byte of a line (x=WIDTH-2,WIDTH-1).
- `frame_done`  out  1  one-cycle pulse on the edge that enqueues the final byte of a frame.
- `overflow`  out  1  sticky; a byte was dropped because the FIFO was full.
- `clear_err`  in  1  synchronous clear of `overflow`.

## Operation

- **Position state:**
  - `x` counter: 0..WIDTH-1. `y` counter: 0..HEIGHT-1.
  - `half` flag: low nibble held.
  - `lo` register: 4 bits.
- **Restart:** `running` is registered. On the edge where `running` is 1 and its registered copy is 0:
  - `x`, `y` and `half` are set to 0.
  - A `new_ctr` in that same cycle is ignored; restart wins.
  - FIFO contents are not flushed.
- **Pixel accept:** on `new_ctr`, when there is no restart, the pixel is taken regardless of the `running` level. The engine raises its final strobe on the same edge it drops `running`.
  - When `half`=0: `lo` ← `ctr_in`, `half` ← 1.
  - When `half`=1: enqueue {sof, eol, `ctr_in`, `lo`}, then `half` ← 0.
    - sof = (x==1 && y==0).
    - eol = (x==WIDTH-1).
  - `x` increments. When x==WIDTH-1, `x` ← 0 and `y` increments.
  - When `y` reaches HEIGHT-1 and x==WIDTH-1, `y` wraps to 0 and `frame_done` pulses.
- **FIFO:**
  - Entries are 10 bits wide. Read and write pointers are log2(FIFO_DEPTH)+1 bits.
  - Full and empty are derived from the pointer MSB and the low bits.
  - The head is driven from registered storage, so the interface is first-word-fall-through.
  - **Push while full:**
    - Without a pop in the same cycle: the byte is dropped, `overflow` ← 1, and the counters still advance to keep alignment.
    - With a pop in the same cycle: both happen and there is no overflow.
  - **Pop while empty:** impossible, since `out_valid`=0.
  - **Simultaneous push and pop** at any occupancy: the count is unchanged.
- **Error clear:** `clear_err` clears `overflow`. If an overflow occurs in the same cycle, set wins.
- **Reset:** asynchronous, at any time including mid-frame.
  - Pointers, `x`, `y`, `half`, `lo`, the registered `running` and `overflow` are all cleared.
  - Output reset values: `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eol`=0, `frame_done`=0, `overflow`=0.

## Timing

- **Latency:** odd-pixel `new_ctr` sampled at edge N → byte visible on `out_data`/`out_valid` after edge N (the same cycle the strobe deasserts), provided the FIFO was empty.
- **Pop:** the head advances on the edge where `out_valid & out_ready`. The next entry is visible right after that edge.
- **Throughput:** one byte per cycle sustained when `out_ready`=1. The input rate is at most one pixel per cycle, so at most one byte per two cycles.
- **`frame_done`:** asserted for exactly the cycle following the enqueue edge of the last byte. It asserts even if that byte was dropped.
- **Outputs:** all outputs are registered or derived from registered state only; there are no combinational paths from inputs.

## Test plan

- **Reset values:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately. After release, `out_valid` stays 0 until two pixels arrive.
- **Full frame:** WIDTH=4, HEIGHT=2, `out_ready`=1, pulse `running` then feed `ctr_in` 1..8 → bytes 0x21 (sof=1), 0x43 (eol=1), 0x65, 0x87 (eol=1). `frame_done` pulses once, after the 8th pixel.
- **Overrun:** FIFO_DEPTH=4, `out_ready`=0, feed 10 pixels → 5th byte dropped, `overflow`=1. Then set `out_ready`=1 → exactly 4 bytes drain in order. Then pulse `clear_err` → `overflow`=0.
- **Push at full with pop:** fill the FIFO to 4 entries, enqueue a byte in the same cycle `out_ready`=1 → no overflow, occupancy stays 4, order preserved.
- **Mid-line restart:** feed 3 pixels, drop and raise `running` → held nibble discarded. Next 2 pixels 0xA, 0xB → byte 0xBA with sof=1.
- **Set-wins collision:** `clear_err` asserted in the same cycle as an overrun → `overflow` remains 1.
